// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  // Arbiter grant state: who currently owns the controller slave port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } grant_t;

  // Default number of reads that may be outstanding at the controller.
  localparam int MAX_PEND_DEF = 8;

  // Width of a requester id held in the tag FIFO (two requesters).
  localparam int ID_W = 1;

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous FIFO remembering which requester issued each outstanding read.
// Push and pop are ignored when full / empty respectively.
module arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave between two
// Avalon-MM masters. Reads are pipelined; a tag FIFO routes each returning
// readdatavalid to the master that issued the read.
//
// Handshake: a master's command is taken on the cycle its waitrequest is 0;
// the controller takes a command when s_read|s_write is high and
// s_waitrequest is low. Read data returns in issue order.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = MAX_PEND_DEF,
  localparam int BE_W    = DATA_W / 8,
  localparam int CW      = $clog2(MAX_PEND) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic [CW-1:0]     pend_count,
  output logic              err_orphan,
  output grant_t            arb_state
);

  grant_t          state;
  logic            last_served;
  logic            gsel;
  logic            granted;
  logic            cur_rd, cur_wr, cur_req, oth_req;
  logic            accept;
  logic            fifo_full, fifo_empty;
  logic [ID_W-1:0] head_id;
  logic            push, pop;

  assign arb_state = state;
  assign gsel      = (state == GRANT1);
  assign granted   = (state != IDLE);

  // Command mux: the granted master drives the controller; read wins a read+write collision.
  always_comb begin
    cur_rd         = gsel ? m1_read : m0_read;
    cur_wr         = gsel ? m1_write : m0_write;
    cur_req        = cur_rd | cur_wr;
    oth_req        = gsel ? (m0_read | m0_write) : (m1_read | m1_write);
    s_address      = gsel ? m1_address : m0_address;
    s_writedata    = gsel ? m1_writedata : m0_writedata;
    s_byteenable   = gsel ? m1_byteenable : m0_byteenable;
    s_read         = granted & cur_rd & ~fifo_full;
    s_write        = granted & cur_wr & ~cur_rd;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state == GRANT0) m0_waitrequest = s_waitrequest | (cur_rd & fifo_full);
    if (state == GRANT1) m1_waitrequest = s_waitrequest | (cur_rd & fifo_full);
  end

  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign push   = accept & s_read;
  assign pop    = s_readdatavalid & ~fifo_empty;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & (head_id == 1'b0);
  assign m1_readdatavalid = pop & (head_id == 1'b1);

  arb_tag_fifo #(.DEPTH(MAX_PEND), .W(ID_W)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (gsel),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pend_count)
  );

  // Grant FSM: round-robin on contention, hold until accept or withdrawal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if ((m0_read | m0_write) && (m1_read | m1_write))
            state <= last_served ? GRANT0 : GRANT1;
          else if (m0_read | m0_write) state <= GRANT0;
          else if (m1_read | m1_write) state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (!cur_req) begin
            state <= IDLE;
          end else if (accept) begin
            last_served <= gsel;
            if (oth_req) state <= gsel ? GRANT0 : GRANT1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error: controller returned data that no issued read accounts for.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_orphan <= 1'b0;
    else if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one linear sequence, with returned
// read data checked against a queue of {port, data} pushed when reads issue.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] m0_address = '0, m1_address = '0, s_address;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [15:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
  logic [1:0]  m0_byteenable = 2'b11, m1_byteenable = 2'b11, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata;
  logic        s_read, s_write;
  logic        s_waitrequest = 1'b0;
  logic [15:0] s_readdata = '0;
  logic        s_readdatavalid = 1'b0;
  logic [3:0]  pend_count;
  logic        err_orphan;
  grant_t      arb_state;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  logic [15:0] data_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_orphan(err_orphan), .arb_state(arb_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle, then score any returned read data.
  task automatic settle();
    logic [16:0] e;
    #1;
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (exp_q.size() == 0) begin
        chk("rdv_unexpected", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdv_port", {30'd0, m1_readdatavalid, m0_readdatavalid}, e[16] ? 32'd2 : 32'd1);
        chk("rdv_data", e[16] ? 32'(m1_readdata) : 32'(m0_readdata), 32'(e[15:0]));
      end
    end
  endtask

  initial begin
    logic port;
    // Reset state
    next_cycle(); next_cycle();
    chk("rst_m0_wait", 32'(m0_waitrequest), 1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 1);
    chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 0);
    chk("rst_cmd", {30'd0, s_read, s_write}, 0);
    chk("rst_pend", 32'(pend_count), 0);
    chk("rst_err", 32'(err_orphan), 0);
    chk("rst_state", 32'(arb_state), 32'(IDLE));
    reset = 1'b0;

    // 1: single m0 write, command one cycle after the request
    next_cycle();
    m0_write = 1; m0_address = 24'h000010; m0_writedata = 16'hBEEF;
    settle();
    chk("t1_idle_wr", 32'(s_write), 0);
    chk("t1_idle_wait", 32'(m0_waitrequest), 1);
    next_cycle(); settle();
    chk("t1_s_write", 32'(s_write), 1);
    chk("t1_addr", 32'(s_address), 32'h10);
    chk("t1_data", 32'(s_writedata), 32'hBEEF);
    chk("t1_m0_wait", 32'(m0_waitrequest), 0);
    chk("t1_m1_wait", 32'(m1_waitrequest), 1);
    next_cycle(); m0_write = 0; settle();
    chk("t1_done", 32'(s_write), 0);
    next_cycle(); settle();
    chk("t1_back_idle", 32'(arb_state), 32'(IDLE));

    // 2: both read continuously; m0 was served last so m1 goes first
    m0_read = 1; m1_read = 1; m0_address = 24'h100; m1_address = 24'h200;
    settle();
    chk("t2_idle", 32'(s_read), 0);
    port = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      chk("t2_s_read", 32'(s_read), 1);
      chk("t2_addr", 32'(s_address), port ? 32'h200 : 32'h100);
      chk("t2_own_wait", port ? 32'(m1_waitrequest) : 32'(m0_waitrequest), 0);
      chk("t2_oth_wait", port ? 32'(m0_waitrequest) : 32'(m1_waitrequest), 1);
      exp_q.push_back({port, 16'hA000 + 16'(i)});
      data_q.push_back(16'hA000 + 16'(i));
      port = ~port;
    end
    next_cycle(); m0_read = 0; m1_read = 0; settle();
    chk("t2_pend", 32'(pend_count), 4);
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1; s_readdata = data_q.pop_front(); settle();
      chk("t2_pend_dn", 32'(pend_count), 32'(4 - i));
      chk("t2_one_rdv", 32'(m0_readdatavalid ^ m1_readdatavalid), 1);
      next_cycle();
    end
    s_readdatavalid = 0;

    // 3: m1 fills the tag FIFO; ninth read stalls
    m1_read = 1; m1_address = 24'h300; settle();
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
      chk("t3_issue", 32'(s_read), 1);
      exp_q.push_back({1'b1, 16'hB000 + 16'(i)});
      data_q.push_back(16'hB000 + 16'(i));
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); settle();
      chk("t3_full_pend", 32'(pend_count), 8);
      chk("t3_full_sread", 32'(s_read), 0);
      chk("t3_full_wait", 32'(m1_waitrequest), 1);
      chk("t3_full_state", 32'(arb_state), 32'(GRANT1));
    end

    // 4: with FIFO full, an m0 write still goes through
    m1_read = 0; m0_write = 1; m0_address = 24'h20; m0_writedata = 16'h1234;
    next_cycle(); settle();
    chk("t4_idle", 32'(arb_state), 32'(IDLE));
    next_cycle(); settle();
    chk("t4_s_write", 32'(s_write), 1);
    chk("t4_wdata", 32'(s_writedata), 32'h1234);
    chk("t4_m0_wait", 32'(m0_waitrequest), 0);
    next_cycle(); m0_write = 0; m1_read = 1; settle();
    chk("t4_pend", 32'(pend_count), 8);

    // 3 continued: a pop while full still blocks; read issues next cycle
    next_cycle(); next_cycle(); settle();
    chk("t3_regrant_stall", 32'(s_read), 0);
    s_readdatavalid = 1; s_readdata = data_q.pop_front(); settle();
    chk("t3_pop_sread", 32'(s_read), 0);
    chk("t3_pop_wait", 32'(m1_waitrequest), 1);
    next_cycle(); s_readdatavalid = 0; settle();
    chk("t3_ninth_issue", 32'(s_read), 1);
    chk("t3_pend7", 32'(pend_count), 7);
    chk("t3_ninth_wait", 32'(m1_waitrequest), 0);
    exp_q.push_back({1'b1, 16'hB008});
    data_q.push_back(16'hB008);

    // 5: controller stalls 5 cycles; grant and address hold
    next_cycle();
    m1_read = 0; m1_write = 1; m1_address = 24'h50; m1_writedata = 16'h5555;
    m0_write = 1; m0_address = 24'h40; m0_writedata = 16'h4444;
    s_waitrequest = 1; settle();
    chk("t5_pend", 32'(pend_count), 8);
    for (int k = 0; k < 5; k++) begin
      chk("t5_state", 32'(arb_state), 32'(GRANT1));
      chk("t5_addr", 32'(s_address), 32'h50);
      chk("t5_m1_wait", 32'(m1_waitrequest), 1);
      chk("t5_m0_wait", 32'(m0_waitrequest), 1);
      next_cycle(); settle();
    end
    s_waitrequest = 0; settle();
    chk("t5_release", 32'(m1_waitrequest), 0);
    next_cycle(); m1_write = 0; settle();
    chk("t5_switch", 32'(arb_state), 32'(GRANT0));
    chk("t5_m0_addr", 32'(s_address), 32'h40);
    chk("t5_m0_data", 32'(s_writedata), 32'h4444);
    chk("t5_m0_go", 32'(m0_waitrequest), 0);
    next_cycle(); m0_write = 0; settle();
    next_cycle();

    // Drain the remaining eight reads to m1
    for (int i = 0; i < 8; i++) begin
      s_readdatavalid = 1; s_readdata = data_q.pop_front(); settle();
      next_cycle();
    end
    s_readdatavalid = 0; settle();
    chk("drain_pend", 32'(pend_count), 0);
    chk("drain_q", 32'(exp_q.size()), 0);

    // 6: orphan readdatavalid is sticky until reset
    s_readdatavalid = 1; s_readdata = 16'hDEAD; settle();
    chk("t6_no_route", {30'd0, m1_readdatavalid, m0_readdatavalid}, 0);
    next_cycle(); s_readdatavalid = 0; settle();
    chk("t6_err", 32'(err_orphan), 1);
    next_cycle(); next_cycle(); settle();
    chk("t6_err_sticky", 32'(err_orphan), 1);
    m0_write = 1; m1_read = 1;
    next_cycle(); next_cycle(); settle();
    reset = 1; settle();
    chk("t6_rst_err", 32'(err_orphan), 0);
    chk("t6_rst_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("t6_rst_state", 32'(arb_state), 32'(IDLE));
    chk("t6_rst_pend", 32'(pend_count), 0);
    next_cycle(); m0_write = 0; m1_read = 0; reset = 0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
